challenge_issuer: RTL and testbench

- Sits directly downstream of the TRNG-fed challenge shift register, which shifts N_RNG fresh random bits into a N_CB-bit word every clk.
- Waits until every bit of that word has been replaced since the last capture, then snapshots it.
- Screens the snapshot with simple health checks (all-zero, all-one, repeat of the last issued challenge).
- Offers accepted challenges to the PUF-evaluation stage over a valid/ready handshake; counts issued and rejected challenges.

---
 rtl/challenge_issuer_pkg.sv | 37 +++
 rtl/challenge_issuer_if.sv | 33 +++
 rtl/challenge_health_chk.sv | 37 +++
 rtl/challenge_issuer.sv | 173 +++++++++++++++++
 tb/tb_challenge_issuer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/challenge_issuer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : challenge_issuer_pkg
// Purpose  : Shared types and constants for the challenge issuer:
//            - FSM state enumeration
//            - fill-cycle derivation and counter-width helpers
//            - width of the consecutive-reject counter
// Revision : 1.0 - initial release
// ============================================================================
package challenge_issuer_pkg;

    // Issuer sequencing: wait for a fully refreshed word, screen it,
    // offer it downstream, or park permanently on a health failure.
    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_CHECK = 2'd1,
        ST_OFFER = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    // Width of the consecutive-reject counter (saturates at 2^REJ_W-1).
    localparam int REJ_W = 8;

    // Number of clocks the upstream shift register needs to replace every
    // bit of an n_cb-bit word when it shifts n_rng bits per clock.
    function automatic int fill_cyc(input int n_cb, input int n_rng);
        return n_cb / n_rng;
    endfunction

    // Counter width able to hold 0..n-1; never narrower than one bit so the
    // degenerate n==1 case still yields a legal vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : challenge_issuer_pkg
`default_nettype wire

// File: rtl/challenge_issuer_if.sv
`default_nettype none
// ============================================================================
// Module   : challenge_issuer_if
// Purpose  : Valid/ready challenge hand-off between the issuer and the PUF
//            evaluation stage.
// Signals  : chal       - held challenge word (N_CB bits)
//            chal_valid - chal is valid and being offered
//            chal_ready - downstream accepts chal on this cycle
// Modports : master - issuer side (drives chal/chal_valid)
//            slave  - PUF evaluation side (drives chal_ready)
// Revision : 1.0 - initial release
// ============================================================================
interface challenge_issuer_if #(
    parameter int N_CB = 64
);
    logic [N_CB-1:0] chal;
    logic            chal_valid;
    logic            chal_ready;

    modport master (
        output chal,
        output chal_valid,
        input  chal_ready
    );

    modport slave (
        input  chal,
        input  chal_valid,
        output chal_ready
    );

endinterface : challenge_issuer_if
`default_nettype wire

// File: rtl/challenge_health_chk.sv
`default_nettype none
// ============================================================================
// Module   : challenge_health_chk
// Purpose  : Combinational screening of a captured candidate challenge.
//            A candidate is rejected when it is all-zero, all-one, or an
//            exact repeat of the last challenge handed downstream.
// Ports    : i_cand     in  N_CB  captured candidate word
//            i_last     in  N_CB  last issued challenge
//            i_last_vld in  1     i_last holds a real issued challenge
//            o_reject   out 1     candidate fails at least one check
// Revision : 1.0 - initial release
// ============================================================================
module challenge_health_chk #(
    parameter int N_CB = 64
) (
    input  wire logic [N_CB-1:0] i_cand,
    input  wire logic [N_CB-1:0] i_last,
    input  wire logic            i_last_vld,
    output logic                 o_reject
);

    logic w_all_zero;
    logic w_all_one;
    logic w_repeat;

    // A stuck source shows up as a constant word.
    assign w_all_zero = ~|i_cand;
    assign w_all_one  =  &i_cand;

    // Until something has been issued, i_last is only its reset value and
    // must not be used to veto the very first candidate.
    assign w_repeat   = i_last_vld && (i_cand == i_last);

    assign o_reject   = w_all_zero | w_all_one | w_repeat;

endmodule : challenge_health_chk
`default_nettype wire

// File: rtl/challenge_issuer.sv
`default_nettype none
// ============================================================================
// Module   : challenge_issuer
// Purpose  : Snapshots the TRNG-fed challenge shift register once every bit
//            has been refreshed since the last capture, screens the snapshot,
//            and offers accepted challenges downstream over valid/ready.
// Ports    : clk        in  1      system clock
//            rst        in  1      synchronous, active-high reset
//            en         in  1      allow fill/capture progress
//            c_in       in  N_CB   live word from the upstream shift register
//            chal_if    master     chal / chal_valid / chal_ready hand-off
//            issued_cnt out CNT_W  challenges handed off (wraps)
//            rej_cnt    out 8      consecutive rejects since last accept
//            health_err out 1      sticky health failure
// Params   : N_CB      challenge width, multiple of N_RNG
//            N_RNG     random bits shifted in per clock upstream
//            REJ_LIMIT consecutive rejects that raise health_err (1..255)
//            CNT_W     issued-challenge counter width
// Revision : 1.0 - initial release
// ============================================================================
module challenge_issuer
    import challenge_issuer_pkg::*;
#(
    parameter int N_CB      = 64,
    parameter int N_RNG     = 4,
    parameter int REJ_LIMIT = 8,
    parameter int CNT_W     = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              en,
    input  wire logic [N_CB-1:0]   c_in,
    challenge_issuer_if.master     chal_if,
    output logic [CNT_W-1:0]       issued_cnt,
    output logic [REJ_W-1:0]       rej_cnt,
    output logic                   health_err
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int              FILL_CYC  = fill_cyc(N_CB, N_RNG);
    localparam int              FILL_W    = cnt_width(FILL_CYC);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_CYC - 1);
    localparam logic [REJ_W-1:0]  REJ_LIM_V = REJ_W'(REJ_LIMIT);
    localparam logic [REJ_W-1:0]  REJ_MAX   = {REJ_W{1'b1}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            r_state;
    logic [FILL_W-1:0] r_fill_cnt;
    logic [N_CB-1:0]   r_cand;
    logic [N_CB-1:0]   r_last;
    logic              r_last_vld;
    logic [N_CB-1:0]   r_chal;
    logic              r_chal_valid;
    logic [CNT_W-1:0]  r_issued_cnt;
    logic [REJ_W-1:0]  r_rej_cnt;
    logic              r_health_err;

    logic              w_reject;
    logic [REJ_W-1:0]  w_rej_next;
    logic              w_handshake;

    // ------------------------------------------------------------------
    // Candidate screening
    // ------------------------------------------------------------------
    challenge_health_chk #(
        .N_CB (N_CB)
    ) u_health_chk (
        .i_cand     (r_cand),
        .i_last     (r_last),
        .i_last_vld (r_last_vld),
        .o_reject   (w_reject)
    );

    // Reject count saturates rather than wrapping back to a "healthy" zero.
    assign w_rej_next  = (r_rej_cnt == REJ_MAX) ? r_rej_cnt
                                                : r_rej_cnt + REJ_W'(1);

    assign w_handshake = r_chal_valid && chal_if.chal_ready;

    // ------------------------------------------------------------------
    // Sequencer. All outputs are registered here; reset has priority so a
    // hand-off that coincides with rst never completes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_FILL;
            r_fill_cnt   <= '0;
            r_cand       <= '0;
            r_last       <= '0;
            r_last_vld   <= 1'b0;
            r_chal       <= '0;
            r_chal_valid <= 1'b0;
            r_issued_cnt <= '0;
            r_rej_cnt    <= '0;
            r_health_err <= 1'b0;
        end else begin
            case (r_state)
                // Count enabled cycles; the FILL_CYC-th one sees a word made
                // entirely of bits shifted in since fill_cnt last restarted.
                ST_FILL: begin
                    if (en) begin
                        if (r_fill_cnt == FILL_LAST) begin
                            r_cand     <= c_in;
                            r_fill_cnt <= '0;
                            r_state    <= ST_CHECK;
                        end else begin
                            r_fill_cnt <= r_fill_cnt + FILL_W'(1);
                        end
                    end
                end

                // Single-cycle decision; en has no effect here.
                ST_CHECK: begin
                    if (w_reject) begin
                        r_rej_cnt <= w_rej_next;
                        if (w_rej_next == REJ_LIM_V) begin
                            r_health_err <= 1'b1;
                            r_state      <= ST_ERR;
                        end else begin
                            r_fill_cnt <= '0;
                            r_state    <= ST_FILL;
                        end
                    end else begin
                        r_chal       <= r_cand;
                        r_chal_valid <= 1'b1;
                        r_rej_cnt    <= '0;
                        r_state      <= ST_OFFER;
                    end
                end

                // Hold the offer indefinitely until accepted. chal keeps its
                // value afterwards; only chal_valid drops.
                ST_OFFER: begin
                    if (w_handshake) begin
                        r_last       <= r_chal;
                        r_last_vld   <= 1'b1;
                        r_issued_cnt <= r_issued_cnt + CNT_W'(1);
                        r_chal_valid <= 1'b0;
                        r_fill_cnt   <= '0;
                        r_state      <= ST_FILL;
                    end
                end

                // Terminal until reset: counters frozen, nothing offered.
                ST_ERR: begin
                    r_chal_valid <= 1'b0;
                    r_health_err <= 1'b1;
                end

                default: begin
                    r_chal_valid <= 1'b0;
                    r_fill_cnt   <= '0;
                    r_state      <= ST_FILL;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign chal_if.chal       = r_chal;
    assign chal_if.chal_valid = r_chal_valid;
    assign issued_cnt         = r_issued_cnt;
    assign rej_cnt            = r_rej_cnt;
    assign health_err         = r_health_err;

endmodule : challenge_issuer
`default_nettype wire

// File: tb/tb_challenge_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_challenge_issuer
// Purpose  : Self-checking bench for challenge_issuer. Expected challenges
//            are queued when stimulus is applied and popped when the DUT
//            offers/hands off. A second instance with REJ_LIMIT=1 shares the
//            stimulus to cover the single-reject error case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_challenge_issuer;
    import challenge_issuer_pkg::*;

    localparam int N_CB  = 64;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              ready;
    logic [N_CB-1:0]   c_in;
    logic [CNT_W-1:0]  issued_cnt,  issued_cnt1;
    logic [REJ_W-1:0]  rej_cnt,     rej_cnt1;
    logic              health_err,  health_err1;

    challenge_issuer_if #(.N_CB(N_CB)) if0 ();
    challenge_issuer_if #(.N_CB(N_CB)) if1 ();

    assign if0.chal_ready = ready;
    assign if1.chal_ready = ready;

    challenge_issuer #(
        .N_CB(N_CB), .N_RNG(4), .REJ_LIMIT(8), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .c_in(c_in), .chal_if(if0.master),
        .issued_cnt(issued_cnt), .rej_cnt(rej_cnt), .health_err(health_err)
    );

    challenge_issuer #(
        .N_CB(N_CB), .N_RNG(4), .REJ_LIMIT(1), .CNT_W(CNT_W)
    ) dut1 (
        .clk(clk), .rst(rst), .en(en), .c_in(c_in), .chal_if(if1.master),
        .issued_cnt(issued_cnt1), .rej_cnt(rej_cnt1), .health_err(health_err1)
    );

    always #5 clk = ~clk;

    int              n_cmp = 0;
    int              n_err = 0;
    logic [N_CB-1:0] exp_q[$];
    logic [N_CB-1:0] exp_c;

    // Returns at the negedge on which chal_valid is first seen (or max hit).
    task automatic run_until_valid(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if0.chal_valid && n < max);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; ready = 1'b0; c_in = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (if0.chal !== '0) begin n_err++; $display("FAIL reset_chal: got %h expected 0", if0.chal); end
        n_cmp++; if (if0.chal_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", if0.chal_valid); end
        n_cmp++; if (issued_cnt !== '0) begin n_err++; $display("FAIL reset_issued: got %0d expected 0", issued_cnt); end
        n_cmp++; if (rej_cnt !== '0) begin n_err++; $display("FAIL reset_rej: got %0d expected 0", rej_cnt); end
        n_cmp++; if (health_err !== 1'b0) begin n_err++; $display("FAIL reset_health: got %b expected 0", health_err); end
    endtask

    task automatic test_basic();
        int n;
        do_reset();
        en = 1'b1; ready = 1'b1; c_in = 64'h0123456789ABCDEF;
        exp_q.push_back(c_in);
        run_until_valid(40, n);
        n_cmp++; if (n !== 17) begin n_err++; $display("FAIL basic_latency: got %0d expected 17", n); end
        exp_c = exp_q.pop_front();
        n_cmp++; if (if0.chal !== exp_c) begin n_err++; $display("FAIL basic_chal: got %h expected %h", if0.chal, exp_c); end
        @(negedge clk);
        n_cmp++; if (if0.chal_valid !== 1'b0) begin n_err++; $display("FAIL basic_pulse: got %b expected 0", if0.chal_valid); end
        n_cmp++; if (issued_cnt !== 16'd1) begin n_err++; $display("FAIL basic_issued: got %0d expected 1", issued_cnt); end
    endtask

    task automatic test_backpressure();
        int   n;
        logic stable;
        do_reset();
        en = 1'b1; ready = 1'b0; c_in = 64'hFEDCBA9876543210;
        exp_q.push_back(c_in);
        run_until_valid(40, n);
        n_cmp++; if (n !== 17) begin n_err++; $display("FAIL bp_latency: got %0d expected 17", n); end
        stable = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            c_in = {$urandom, $urandom};
            @(negedge clk);
            if (!if0.chal_valid || if0.chal !== 64'hFEDCBA9876543210 || issued_cnt !== '0)
                stable = 1'b0;
        end
        n_cmp++; if (stable !== 1'b1) begin n_err++; $display("FAIL bp_hold: got %b expected 1", stable); end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        exp_c = exp_q.pop_front();
        n_cmp++; if (if0.chal !== exp_c) begin n_err++; $display("FAIL bp_chal_kept: got %h expected %h", if0.chal, exp_c); end
        n_cmp++; if (if0.chal_valid !== 1'b0) begin n_err++; $display("FAIL bp_valid_drop: got %b expected 0", if0.chal_valid); end
        n_cmp++; if (issued_cnt !== 16'd1) begin n_err++; $display("FAIL bp_issued: got %0d expected 1", issued_cnt); end
        repeat (3) @(negedge clk);
        n_cmp++; if (issued_cnt !== 16'd1) begin n_err++; $display("FAIL bp_issued_once: got %0d expected 1", issued_cnt); end
    endtask

    task automatic test_zero_reject();
        logic saw_valid;
        do_reset();
        en = 1'b1; ready = 1'b1; c_in = '0;
        saw_valid = 1'b0;
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            if (if0.chal_valid || if1.chal_valid) saw_valid = 1'b1;
            if (c % 17 == 0 && c <= 136) begin
                n_cmp++; if (rej_cnt !== 8'(c / 17)) begin n_err++; $display("FAIL zero_rej_cnt: cycle %0d got %0d expected %0d", c, rej_cnt, c / 17); end
            end
            if (c == 135) begin
                n_cmp++; if (health_err !== 1'b0) begin n_err++; $display("FAIL zero_health_early: got %b expected 0", health_err); end
            end
            if (c == 136) begin
                n_cmp++; if (health_err !== 1'b1) begin n_err++; $display("FAIL zero_health_set: got %b expected 1", health_err); end
            end
            if (c == 16) begin
                n_cmp++; if (health_err1 !== 1'b0) begin n_err++; $display("FAIL lim1_health_early: got %b expected 0", health_err1); end
            end
            if (c == 17) begin
                n_cmp++; if (health_err1 !== 1'b1) begin n_err++; $display("FAIL lim1_health_set: got %b expected 1", health_err1); end
            end
        end
        n_cmp++; if (saw_valid !== 1'b0) begin n_err++; $display("FAIL zero_no_valid: got %b expected 0", saw_valid); end
        n_cmp++; if (rej_cnt !== 8'd8) begin n_err++; $display("FAIL zero_rej_frozen: got %0d expected 8", rej_cnt); end
        n_cmp++; if (health_err !== 1'b1) begin n_err++; $display("FAIL zero_health_hold: got %b expected 1", health_err); end
        n_cmp++; if (issued_cnt !== '0) begin n_err++; $display("FAIL zero_issued: got %0d expected 0", issued_cnt); end
        n_cmp++; if (rej_cnt1 !== 8'd1 || health_err1 !== 1'b1 || issued_cnt1 !== '0 || if1.chal !== '0)
            begin n_err++; $display("FAIL lim1_frozen: got rej=%0d err=%b iss=%0d chal=%h expected 1/1/0/0", rej_cnt1, health_err1, issued_cnt1, if1.chal); end
        do_reset();
        n_cmp++; if (health_err !== 1'b0) begin n_err++; $display("FAIL zero_health_clear: got %b expected 0", health_err); end
    endtask

    task automatic test_repeat();
        int   n;
        logic saw_valid;
        do_reset();
        en = 1'b1; ready = 1'b1; c_in = {8{8'hA5}};
        exp_q.push_back(c_in);
        run_until_valid(40, n);
        n_cmp++; if (n !== 17) begin n_err++; $display("FAIL rep_latency1: got %0d expected 17", n); end
        exp_c = exp_q.pop_front();
        n_cmp++; if (if0.chal !== exp_c) begin n_err++; $display("FAIL rep_chal1: got %h expected %h", if0.chal, exp_c); end
        @(negedge clk);
        saw_valid = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            if (if0.chal_valid) saw_valid = 1'b1;
        end
        n_cmp++; if (rej_cnt !== 8'd1 || saw_valid !== 1'b0) begin n_err++; $display("FAIL rep_reject: got rej=%0d valid_seen=%b expected 1/0", rej_cnt, saw_valid); end
        c_in = {8{8'h5A}};
        exp_q.push_back(c_in);
        run_until_valid(40, n);
        n_cmp++; if (n !== 17) begin n_err++; $display("FAIL rep_latency2: got %0d expected 17", n); end
        exp_c = exp_q.pop_front();
        n_cmp++; if (if0.chal !== exp_c) begin n_err++; $display("FAIL rep_chal2: got %h expected %h", if0.chal, exp_c); end
        n_cmp++; if (rej_cnt !== 8'd0) begin n_err++; $display("FAIL rep_rej_clear: got %0d expected 0", rej_cnt); end
    endtask

    task automatic test_en_toggle();
        int n;
        do_reset();
        ready = 1'b1; c_in = 64'h13579BDF2468ACE0;
        exp_q.push_back(c_in);
        n = 0;
        do begin
            en = (n % 2 == 0);
            @(negedge clk);
            n++;
        end while (!if0.chal_valid && n < 80);
        n_cmp++; if (n !== 32) begin n_err++; $display("FAIL en_latency: got %0d expected 32", n); end
        exp_c = exp_q.pop_front();
        n_cmp++; if (if0.chal !== exp_c) begin n_err++; $display("FAIL en_chal: got %h expected %h", if0.chal, exp_c); end
    endtask

    task automatic test_rst_offer();
        int n;
        do_reset();
        en = 1'b1; ready = 1'b0; c_in = 64'hC0FFEE00DEADBEEF;
        run_until_valid(40, n);
        n_cmp++; if (n !== 17) begin n_err++; $display("FAIL rst_latency1: got %0d expected 17", n); end
        ready = 1'b1; rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (if0.chal_valid !== 1'b0 || issued_cnt !== '0) begin n_err++; $display("FAIL rst_no_handshake: got valid=%b issued=%0d expected 0/0", if0.chal_valid, issued_cnt); end
        rst = 1'b0; ready = 1'b0;
        exp_q.push_back(c_in);
        run_until_valid(40, n);
        n_cmp++; if (n !== 17) begin n_err++; $display("FAIL rst_latency2: got %0d expected 17", n); end
        exp_c = exp_q.pop_front();
        n_cmp++; if (if0.chal !== exp_c) begin n_err++; $display("FAIL rst_chal: got %h expected %h", if0.chal, exp_c); end
        ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (issued_cnt !== 16'd1) begin n_err++; $display("FAIL rst_issued: got %0d expected 1", issued_cnt); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; ready = 1'b0; c_in = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_reject();
        test_repeat();
        test_en_toggle();
        test_rst_offer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_challenge_issuer
`default_nettype wire
